// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_e    : converter FSM states (IDLE, CONVERT, DONE)
//   - CNT_W      : width of the iteration counter, clog2(BIN_W+1)
//   - MAX_VAL    : largest value representable in BCD_DIGITS digits
//   - SAT_BCD    : all-nines pattern presented when a value saturates
//   - BLANK_RST  : leading-zero mask of a zero value (every digit but 0 blank)
//   - lz_mask()  : leading-zero mask of a packed BCD word
// The module parameters of bcd_converter default to BCD_BIN_W / BCD_DIGITS;
// the constants here are sized for those defaults.
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_BIN_W  = 27;
    localparam int BCD_DIGITS = 8;
    localparam int CNT_W      = $clog2(BCD_BIN_W + 1);

    localparam logic [BCD_BIN_W-1:0]    MAX_VAL   = 27'd99_999_999;
    localparam logic [4*BCD_DIGITS-1:0] SAT_BCD   = 32'h9999_9999;
    localparam logic [BCD_DIGITS-1:0]   BLANK_RST = 8'b1111_1110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Scan from the most significant digit down: a digit is blank while it
    // and every digit above it are zero. Digit 0 is always shown.
    function automatic logic [BCD_DIGITS-1:0] lz_mask(
        input logic [4*BCD_DIGITS-1:0] bcd
    );
        logic [BCD_DIGITS-1:0] mask;
        logic                  zero_run;
        mask     = {BCD_DIGITS{1'b0}};
        zero_run = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (bcd[4*i +: 4] == 4'd0);
            mask[i]  = zero_run;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_converter_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell for one BCD digit: if the digit
// is 5 or more, add 3 so that the following left shift carries correctly into
// the next decimal digit. The add is 4-bit and wraps; no carry leaves the cell.
// Ports:
//   digit    in  [3:0]  digit before correction
//   adjusted out [3:0]  digit after correction
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add-3 correction for digits 5..15.
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3). One value is converted
// per request over a fixed BIN_W+1 cycles; results are held between
// conversions. Values above 10^DIGITS-1 saturate to all nines and set
// overflow_out. blank_out marks leading-zero digits for the display driver.
// Ports:
//   clk_in        in   1         system clock, rising edge
//   rst_n_in      in   1         asynchronous active-low reset
//   start_in      in   1         conversion request (honoured in IDLE/DONE)
//   bin_in        in   BIN_W     unsigned value, captured on the accepting edge
//   busy_out      out  1         high while in CONVERT
//   done_out      out  1         one-cycle pulse when results update
//   bcd_out       out  4*DIGITS  packed BCD, digit 0 in [3:0]
//   overflow_out  out  1         last captured value exceeded 10^DIGITS-1
//   blank_out     out  DIGITS    leading-zero mask, bit 0 never set
// -----------------------------------------------------------------------------
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BCD_BIN_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow_out,
    output logic [DIGITS-1:0]     blank_out
);

    localparam int CTR_W = $clog2(BIN_W + 1);

    // FSM state
    state_e state_r;
    state_e next_state_s;

    // FSM controls
    logic load_s;     // capture bin_in and restart the conversion
    logic step_s;     // one add-3 / shift iteration
    logic finish_s;   // register results and pulse done_out

    // Datapath
    logic [BIN_W-1:0]    sr_r;          // binary shift register
    logic [4*DIGITS-1:0] acc_r;         // BCD accumulator
    logic [CTR_W-1:0]    cnt_r;         // remaining iterations
    logic                ovf_r;         // captured value out of range
    logic [4*DIGITS-1:0] adj_s;         // accumulator after add-3 correction
    logic [4*DIGITS-1:0] acc_shift_s;   // accumulator after the left shift
    logic [BIN_W-1:0]    sr_shift_s;    // shift register after the left shift

    // Per-digit add-3 correction cells.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (acc_r[4*g +: 4]),
                .adjusted (adj_s[4*g +: 4])
            );
        end
    endgenerate

    // Combined {accumulator, shift register} left shift after correction.
    always_comb begin
        acc_shift_s = {adj_s[4*DIGITS-2:0], sr_r[BIN_W-1]};
        sr_shift_s  = {sr_r[BIN_W-2:0], 1'b0};
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and control decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    load_s       = 1'b1;
                    next_state_s = ST_CONVERT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                // start_in is deliberately ignored here: requests while busy
                // are dropped. A counter of 0 is unreachable but also exits,
                // so a corrupted counter cannot trap the FSM.
                step_s = 1'b1;
                if (cnt_r <= CTR_W'(1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CONVERT;
                end
            end
            ST_DONE: begin
                finish_s = 1'b1;
                if (start_in) begin
                    load_s       = 1'b1;
                    next_state_s = ST_CONVERT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath: capture, iterate, hold.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sr_r  <= '0;
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (load_s) begin
            sr_r  <= bin_in;
            acc_r <= '0;
            cnt_r <= CTR_W'(BIN_W);
            ovf_r <= (bin_in > MAX_VAL);
        end else if (step_s) begin
            sr_r  <= sr_shift_s;
            acc_r <= acc_shift_s;
            cnt_r <= cnt_r - CTR_W'(1);
            // A bit shifted out of the top digit can only come from an
            // out-of-range value; folding it in keeps the flag sticky even if
            // the capture-time compare were ever bypassed.
            ovf_r <= ovf_r | adj_s[4*DIGITS-1];
        end else begin
            sr_r  <= sr_r;
            acc_r <= acc_r;
            cnt_r <= cnt_r;
            ovf_r <= ovf_r;
        end
    end

    // Registered outputs; results change only on the edge leaving DONE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            bcd_out      <= '0;
            overflow_out <= 1'b0;
            blank_out    <= BLANK_RST;
        end else begin
            busy_out <= (next_state_s == ST_CONVERT);
            done_out <= finish_s;
            if (finish_s) begin
                overflow_out <= ovf_r;
                if (ovf_r) begin
                    bcd_out   <= SAT_BCD;
                    blank_out <= '0;
                end else begin
                    bcd_out   <= acc_r;
                    blank_out <= lz_mask(acc_r);
                end
            end else begin
                bcd_out      <= bcd_out;
                overflow_out <= overflow_out;
                blank_out    <= blank_out;
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
// Scoreboarded bench for bcd_converter. Stimulus pushes the expected result
// (decimal digits computed arithmetically) with its due cycle; a monitor pops
// and compares on every done_out pulse.
// -----------------------------------------------------------------------------
module tb_bcd_converter;

    localparam int LAT = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [26:0] bin = 27'd0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  blank;

    bcd_converter dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start),
        .bin_in       (bin),
        .busy_out     (busy),
        .done_out     (done),
        .bcd_out      (bcd),
        .overflow_out (ovf),
        .blank_out    (blank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    logic [31:0] last_bcd = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: decimal digits by division, blanking by magnitude.
    function automatic exp_t model(input int unsigned v, input int due);
        exp_t        e;
        int unsigned n;
        int unsigned p;
        e.due = due;
        e.ovf = (v > 32'd99_999_999);
        e.bcd = 32'd0;
        e.blank = 8'd0;
        if (e.ovf) begin
            e.bcd = 32'h9999_9999;
        end else begin
            n = v;
            for (int i = 0; i < 8; i++) begin
                e.bcd[4*i +: 4] = 4'(n % 10);
                n = n / 10;
            end
            p = 1;
            for (int i = 1; i < 8; i++) begin
                p = p * 10;
                e.blank[i] = (v < p);
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            n_done++;
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bcd", 64'(bcd), 64'(e.bcd));
                check("overflow", 64'(ovf), 64'(e.ovf));
                check("blank", 64'(blank), 64'(e.blank));
                check("latency", 64'(cyc), 64'(e.due));
                last_bcd = e.bcd;
            end
        end
    end

    // Issue one request from idle; called at a negedge.
    task automatic send(input int unsigned v);
        @(negedge clk);
        start = 1'b1;
        bin = 27'(v);
        exp_q.push_back(model(v, cyc + 1 + LAT));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic convert(input int unsigned v);
        send(v);
        wait_drain();
    endtask

    // start held high over n results; busy must drop only in each DONE cycle.
    task automatic hold_run(input int n, input int unsigned va, input int unsigned vb);
        int zeros = 0;
        int unsigned v;
        @(negedge clk);
        start = 1'b1;
        bin = 27'(va);
        exp_q.push_back(model(va, cyc + 1 + LAT));
        for (int j = 0; j < n; j++) begin
            for (int t = 0; t < LAT; t++) begin
                @(negedge clk);
                if (busy !== 1'b1) zeros++;
                if (t == LAT - 1) begin
                    if (j < n - 1) begin
                        v = ((j % 2) == 0) ? vb : va;
                        bin = 27'(v);
                        exp_q.push_back(model(v, cyc + 1 + LAT));
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        wait_drain();
        check("busy_low_cycles", 64'(zeros), 64'(n));
    endtask

    initial begin
        int done_before;
        int unsigned v;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_blank", 64'(blank), 64'hFE);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        convert(0);
        convert(12_345_678);
        convert(907);
        convert(99_999_999);
        convert(100_000_000);
        convert(134_217_727);
        convert(5);

        // Outputs hold between conversions
        repeat (5) @(negedge clk);
        check("hold_bcd", 64'(bcd), 64'(last_bcd));

        // Request while busy is dropped
        done_before = n_done;
        send(42);
        repeat (3) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        bin = 27'd7;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (LAT + 4) @(negedge clk);
        check("dropped_req_done_count", 64'(n_done - done_before), 64'd1);
        check("dropped_req_bcd", 64'(bcd), 64'h0000_0042);

        // Back-to-back with start held
        hold_run(4, $urandom_range(0, 99_999_999), $urandom_range(0, 134_217_727));

        // Reset mid-conversion
        done_before = n_done;
        @(negedge clk);
        start = 1'b1;
        bin = 27'd555;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_bcd", 64'(bcd), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_blank", 64'(blank), 64'hFE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("midrst_no_done", 64'(n_done - done_before), 64'd0);
        convert(555);

        // Randomized values across small, in-range and overflow ranges
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: v = $urandom_range(0, 999);
                1: v = $urandom_range(0, 99_999_999);
                default: v = $urandom_range(0, 134_217_727);
            endcase
            convert(v);
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that produces the 8-digit packed-BCD word consumed by the seven-segment display driver. It sits between binary datapath sources (score counters, PS/2 scan-code tallies) and the display. It converts one value per request over a fixed number of cycles, holds the result stable between conversions, and reports saturation and leading-zero blanking.

## Interface
Parameters:
- BIN_W, 27, binary input width; 27 bits is the minimum that covers 99,999,999.
- DIGITS, 8, number of BCD digits; the output width is 4*DIGITS.

Ports:
- clk_in  input  1  system clock; all state on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  conversion request; sampled only in IDLE or DONE.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge.
- busy_out  output  1  high while a conversion is in progress (CONVERT state).
- done_out  output  1  one-cycle pulse; bcd_out, overflow_out and blank_out are valid from this cycle onward.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0].
- overflow_out  output  1  the last captured value exceeded 10^DIGITS−1.
- blank_out  output  DIGITS  bit i set means digit i is a leading zero; bit 0 is never set.

## Operation
- States: IDLE, CONVERT, DONE.
  - IDLE: if start_in, capture bin_in into the shift register, clear the BCD accumulator, load the iteration counter with BIN_W, and go to CONVERT.
  - CONVERT: each cycle, every BCD digit ≥5 has 3 added. Then {accumulator, shift register} shifts left by one and the counter decrements. When the counter reaches 1, the current iteration is the last one and the next state is DONE.
  - DONE: lasts one cycle. Register the outputs and pulse done_out. If start_in is high in DONE, capture the new value and go directly to CONVERT. Otherwise go to IDLE.
- Overflow: the value is compared with 10^DIGITS−1 at capture and the flag is kept internally. The conversion still runs, so latency stays constant. In DONE, an overflowed value produces bcd_out = all digits 9 (32'h9999_9999) and overflow_out = 1.
- blank_out: computed in DONE from the final BCD word. Scanning from the most significant digit down, digit i is blank when it and all higher digits are zero, except digit 0. A zero value therefore gives 8'b1111_1110. When overflow is set, blank_out = 0.
- start_in is ignored in CONVERT. A request made while busy is dropped, not queued.
- bcd_out, overflow_out and blank_out change only on the DONE edge. Between conversions they hold their values.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert on clk_in): state = IDLE, busy_out = 0, done_out = 0, bcd_out = 0, overflow_out = 0, blank_out = 8'b1111_1110, counter = 0.
- Accepting edge E samples start_in. busy_out is high from E through E+BIN_W. done_out is high for exactly the one cycle after edge E+BIN_W+1, and the outputs update on that same edge.
- Fixed latency is BIN_W+1 edges (28 for the defaults). This holds for every value, including overflowed ones.
- Back-to-back: start_in held in DONE gives a throughput of one result per BIN_W+1 cycles.
- Reset asserted mid-conversion: the conversion is aborted, all outputs return to their reset values at once, and done_out is not pulsed.
- Arithmetic: each digit's add-3 is 4-bit with no carry out. The counter width is clog2(BIN_W+1).

## Structure
- Package bcd_pkg holds:
  - the state enum;
  - localparams for the counter width, MAX_VAL = 10^DIGITS−1, and SAT_BCD (all-nines pattern);
  - a function that computes the leading-zero mask.
- Sub-module bcd_digit_adj: a combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times with a generate loop.

## Test plan
- Reset, then bin_in = 0 with start_in pulsed → done_out exactly 28 edges later; bcd_out = 32'h0000_0000, blank_out = 8'b1111_1110, overflow_out = 0.
- bin_in = 12,345,678 → bcd_out = 32'h1234_5678, blank_out = 0. Then bin_in = 907 → bcd_out = 32'h0000_0907, blank_out = 8'b1111_1000.
- bin_in = 99,999,999 → bcd_out = 32'h9999_9999, overflow_out = 0. Then bin_in = 100,000,000 → bcd_out = 32'h9999_9999, overflow_out = 1, blank_out = 0, still 28 cycles.
- start_in pulsed with value 42, then start_in with value 7 at cycle 10 while busy → exactly one done_out; bcd_out = 32'h0000_0042.
- start_in held high continuously over alternating values → done_out every 28 cycles; each result matches its captured value; busy_out stays high across the DONE cycle gaps except the single DONE cycle.
- rst_n_in asserted at cycle 15 of a conversion of 555 → outputs at reset values immediately; no done_out; a fresh conversion of 555 after reset gives 32'h0000_0555.
